adc_frame_align_ctrl: RTL and testbench

- Bitslip alignment controller for the LVDS ADC receive path.
- Watches the 14-bit deserialized frame-clock word, issues single-cycle bitslip pulses to the frame and data ISERDES lanes until the word equals the expected frame pattern, then verifies stability.
- Raises FrmAlignDone, which the data-lane block forwards as its own align-done.
- Supervises lock after alignment and re-aligns automatically on sustained loss.

---
 rtl/adc_lvds_pkg.sv | 18 +
 rtl/adc_frame_align_ctrl_if.sv | 26 ++
 rtl/adc_frame_align_ctrl.sv | 139 +++++++++++++
 tb/tb_adc_frame_align_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/adc_lvds_pkg.sv
// Shared definitions for the LVDS ADC receive path: frame word geometry and
// the bitslip alignment state encoding.
package adc_lvds_pkg;

  localparam int              LVDS_DW     = 14;
  localparam logic [13:0]     FRM_PATTERN = 14'h3F80;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    VERIFY,
    DONE,
    FAIL
  } alignSt_t;

endpackage

// File: rtl/adc_frame_align_ctrl_if.sv
// Frame-alignment bus between the bitslip controller (master) and the
// ISERDES receive path (slave).
interface adc_frame_align_ctrl_if
  import adc_lvds_pkg::*;
#(
  parameter int DW  = LVDS_DW,
  parameter int SCW = 4
);
  logic           AlignEn;
  logic [DW-1:0]  FrmData;
  logic           FrmBitslip;
  logic           FrmAlignDone;
  logic           FrmAlignErr;
  logic [SCW-1:0] SlipCount;
  logic           LockLost;

  modport master (
    input  AlignEn, FrmData,
    output FrmBitslip, FrmAlignDone, FrmAlignErr, SlipCount, LockLost
  );

  modport slave (
    output AlignEn, FrmData,
    input  FrmBitslip, FrmAlignDone, FrmAlignErr, SlipCount, LockLost
  );
endinterface

// File: rtl/adc_frame_align_ctrl.sv
// Bitslip alignment controller: slips the ISERDES lanes until the frame word
// matches PATTERN, verifies it, then supervises lock and re-aligns on loss.
module adc_frame_align_ctrl
  import adc_lvds_pkg::*;
#(
  parameter int            DW         = LVDS_DW,
  parameter logic [DW-1:0] PATTERN    = FRM_PATTERN,
  parameter int            SETTLE_CYC = 4,
  parameter int            VERIFY_CNT = 16,
  parameter int            MAX_SLIPS  = 14,
  parameter int            LOSS_CNT   = 8
) (
  input  logic                  DatClkDiv,
  input  logic                  DatRstN,
  adc_frame_align_ctrl_if.master bus
);
  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int TW  = $clog2(SETTLE_CYC + 1);
  localparam int MW  = $clog2(VERIFY_CNT + 1);
  localparam int LW  = $clog2(LOSS_CNT + 1);

  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(MAX_SLIPS);
  localparam logic [TW-1:0]  SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0]  MATCH_ONE   = MW'(1);
  localparam logic [MW-1:0]  VERIFY_LAST = MW'(VERIFY_CNT - 1);
  localparam logic [LW-1:0]  LOSS_LAST   = LW'(LOSS_CNT - 1);
  localparam logic [LW-1:0]  LOSS_MAX    = LW'(LOSS_CNT);

  alignSt_t       st;
  logic [TW-1:0]  settleCnt;
  logic [MW-1:0]  matchCnt;
  logic [LW-1:0]  missCnt;
  logic [SCW-1:0] slipCnt;
  logic           bitslip, alignDone, alignErr, lockLost;
  logic           match;

  assign match = (bus.FrmData == PATTERN);

  always_ff @(posedge DatClkDiv) begin
    if (!DatRstN || !bus.AlignEn) begin
      st        <= IDLE;
      settleCnt <= '0;
      matchCnt  <= '0;
      missCnt   <= '0;
      slipCnt   <= '0;
      bitslip   <= 1'b0;
      alignDone <= 1'b0;
      alignErr  <= 1'b0;
      lockLost  <= 1'b0;
    end else begin
      bitslip  <= 1'b0;
      lockLost <= 1'b0;
      case (st)
        IDLE: begin
          st        <= SETTLE;
          slipCnt   <= '0;
          settleCnt <= '0;
        end
        SETTLE: begin
          if (settleCnt == SETTLE_LAST) begin
            st        <= CHECK;
            settleCnt <= '0;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        CHECK: begin
          if (match) begin
            matchCnt <= MATCH_ONE;
            if (VERIFY_CNT == 1) begin
              st        <= DONE;
              alignDone <= 1'b1;
              missCnt   <= '0;
            end else begin
              st <= VERIFY;
            end
          end else if (slipCnt == SLIP_MAX) begin
            st       <= FAIL;
            alignErr <= 1'b1;
          end else begin
            st      <= SLIP;
            bitslip <= 1'b1;
          end
        end
        SLIP: begin
          slipCnt   <= (slipCnt == SLIP_MAX) ? slipCnt : slipCnt + 1'b1;
          settleCnt <= '0;
          st        <= SETTLE;
        end
        VERIFY: begin
          if (match) begin
            if (matchCnt == VERIFY_LAST) begin
              st        <= DONE;
              alignDone <= 1'b1;
              missCnt   <= '0;
            end else begin
              matchCnt <= matchCnt + 1'b1;
            end
          end else if (slipCnt == SLIP_MAX) begin
            st       <= FAIL;
            alignErr <= 1'b1;
          end else begin
            st      <= SLIP;
            bitslip <= 1'b1;
          end
        end
        DONE: begin
          // Loss is flagged one cycle ahead of the re-align slip so LockLost
          // and the bitslip pulse never coincide.
          if (missCnt == LOSS_MAX) begin
            st      <= SLIP;
            bitslip <= 1'b1;
            missCnt <= '0;
          end else if (!match) begin
            if (missCnt == LOSS_LAST) begin
              missCnt   <= LOSS_MAX;
              lockLost  <= 1'b1;
              alignDone <= 1'b0;
              slipCnt   <= '0;
            end else begin
              missCnt <= missCnt + 1'b1;
            end
          end else begin
            missCnt <= '0;
          end
        end
        FAIL: alignErr <= 1'b1;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.FrmBitslip   = bitslip;
  assign bus.FrmAlignDone = alignDone;
  assign bus.FrmAlignErr  = alignErr;
  assign bus.SlipCount    = slipCnt;
  assign bus.LockLost     = lockLost;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Directed bench for adc_frame_align_ctrl: per-cycle output capture against
// hand-derived cycle numbers at default parameters.
module tb_adc_frame_align_ctrl;
  import adc_lvds_pkg::*;

  localparam int DW  = 14;
  localparam int SCW = 4;
  localparam logic [13:0] PAT = 14'h3F80;

  logic DatClkDiv = 1'b0;
  logic DatRstN;
  always #5 DatClkDiv = ~DatClkDiv;

  adc_frame_align_ctrl_if #(.DW(DW), .SCW(SCW)) bus();

  adc_frame_align_ctrl #(
    .DW(DW), .PATTERN(PAT), .SETTLE_CYC(4), .VERIFY_CNT(16),
    .MAX_SLIPS(14), .LOSS_CNT(8)
  ) dut (
    .DatClkDiv (DatClkDiv),
    .DatRstN   (DatRstN),
    .bus       (bus)
  );

  int errs   = 0;
  int checks = 0;

  logic bsA[128], doneA[128], errA[128], lockA[128];
  int   slipA[128];
  int   nPulse, firstDone, firstLock;
  int   pulseCyc[16];
  int   acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] rotl(input logic [13:0] w, input int k);
    logic [27:0] t;
    t = {w, w};
    t = t << k;
    return t[27:14];
  endfunction

  // 0 aligned, 1 three slips needed, 2 never matches, 3 glitch in VERIFY, 4 loss in DONE
  function automatic logic [13:0] stim(input int mode, input int c, input int n);
    case (mode)
      0: return PAT;
      1: return rotl(PAT, (17 - n) % 14);
      2: return 14'h0000;
      3: return (c == 15) ? 14'h0000 : PAT;
      4: return ((c >= 21 && c <= 27) || (c >= 29 && c <= 36)) ? 14'h0000 : PAT;
      default: return PAT;
    endcase
  endfunction

  task automatic sample(input int c);
    bsA[c]   = bus.FrmBitslip;
    doneA[c] = bus.FrmAlignDone;
    errA[c]  = bus.FrmAlignErr;
    lockA[c] = bus.LockLost;
    slipA[c] = int'(bus.SlipCount);
    if (bus.FrmBitslip === 1'b1) begin
      if (nPulse < 16) pulseCyc[nPulse] = c;
      nPulse++;
    end
    if (bus.FrmAlignDone === 1'b1 && firstDone < 0) firstDone = c;
    if (bus.LockLost === 1'b1 && firstLock < 0) firstLock = c;
  endtask

  // Cycle 0 is the IDLE cycle in which AlignEn is first driven high.
  task automatic run_case(input int mode, input int ncyc, input int dropAt);
    nPulse = 0; firstDone = -1; firstLock = -1;
    for (int i = 0; i < 16; i++) pulseCyc[i] = -1;
    bus.AlignEn = 1'b0;
    bus.FrmData = '0;
    DatRstN = 1'b0;
    repeat (2) begin @(posedge DatClkDiv); #1; end
    DatRstN = 1'b1;
    @(posedge DatClkDiv); #1;
    sample(0);
    bus.AlignEn = 1'b1;
    bus.FrmData = stim(mode, 0, 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge DatClkDiv); #1;
      sample(c);
      if (c == dropAt) bus.AlignEn = 1'b0;
      bus.FrmData = stim(mode, c, nPulse);
    end
  endtask

  initial begin
    // reset dominates an asserted enable
    DatRstN = 1'b0;
    bus.AlignEn = 1'b1;
    bus.FrmData = PAT;
    repeat (3) begin @(posedge DatClkDiv); #1; end
    chk("rst_bitslip", 32'(bus.FrmBitslip), 0);
    chk("rst_done",    32'(bus.FrmAlignDone), 0);
    chk("rst_err",     32'(bus.FrmAlignErr), 0);
    chk("rst_slipcnt", 32'(bus.SlipCount), 0);
    chk("rst_locklost",32'(bus.LockLost), 0);

    run_case(0, 30, -1);
    chk("al_pulses",   32'(nPulse), 0);
    chk("al_done20",   32'(doneA[20]), 0);
    chk("al_done21",   32'(doneA[21]), 1);
    chk("al_first",    32'(firstDone), 21);
    chk("al_slip",     32'(slipA[21]), 0);

    run_case(1, 45, -1);
    chk("s3_pulses",   32'(nPulse), 3);
    chk("s3_p0",       32'(pulseCyc[0]), 6);
    chk("s3_p1",       32'(pulseCyc[1]), 12);
    chk("s3_p2",       32'(pulseCyc[2]), 18);
    chk("s3_width",    32'(bsA[7]), 0);
    chk("s3_done38",   32'(doneA[38]), 0);
    chk("s3_done39",   32'(doneA[39]), 1);
    chk("s3_slip",     32'(slipA[39]), 3);

    run_case(2, 93, 91);
    chk("nm_pulses",   32'(nPulse), 14);
    chk("nm_p13",      32'(pulseCyc[13]), 84);
    chk("nm_err89",    32'(errA[89]), 0);
    chk("nm_err90",    32'(errA[90]), 1);
    chk("nm_done90",   32'(doneA[90]), 0);
    chk("nm_slip90",   32'(slipA[90]), 14);
    chk("nm_err91",    32'(errA[91]), 1);
    chk("nm_errclr",   32'(errA[92]), 0);

    run_case(3, 40, -1);
    chk("gl_pulses",   32'(nPulse), 1);
    chk("gl_p0",       32'(pulseCyc[0]), 16);
    chk("gl_first",    32'(firstDone), 37);
    chk("gl_done36",   32'(doneA[36]), 0);
    chk("gl_slip",     32'(slipA[37]), 1);

    run_case(4, 40, -1);
    chk("ll_first",    32'(firstLock), 37);
    chk("ll_done36",   32'(doneA[36]), 1);
    chk("ll_done37",   32'(doneA[37]), 0);
    chk("ll_lock38",   32'(lockA[38]), 0);
    chk("ll_bs37",     32'(bsA[37]), 0);
    chk("ll_bs38",     32'(bsA[38]), 1);
    chk("ll_pulses",   32'(nPulse), 1);
    chk("ll_slip37",   32'(slipA[37]), 0);

    // reset while settling after the second slip
    run_case(1, 14, -1);
    chk("mr_slip14",   32'(slipA[14]), 2);
    DatRstN = 1'b0;
    @(posedge DatClkDiv); #1;
    chk("mr_bitslip",  32'(bus.FrmBitslip), 0);
    chk("mr_done",     32'(bus.FrmAlignDone), 0);
    chk("mr_err",      32'(bus.FrmAlignErr), 0);
    chk("mr_slipcnt",  32'(bus.SlipCount), 0);
    acc = 0;
    repeat (8) begin @(posedge DatClkDiv); #1; acc += int'(bus.FrmBitslip); end
    chk("mr_noslip",   32'(acc), 0);
    DatRstN = 1'b1;

    // enable drops while CHECK sees a mismatch: pending slip must not fire
    run_case(2, 15, 5);
    chk("dis_pulses",  32'(nPulse), 0);
    chk("dis_slip",    32'(slipA[15]), 0);
    chk("dis_err",     32'(errA[15]), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
